io_timer: RTL and testbench

// - Memory-mapped 64-bit timer peripheral; responder on the core's IO data bus (same req/ready/be

---
 rtl/io_timer_if.sv | 25 ++
 rtl/io_timer.sv | 156 +++++++++++++++
 tb/tb_io_timer.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_timer_if.sv
// IO data-bus bundle between the core (master) and the timer (slave).
// Requests are level-held until the matching one-cycle ready pulse.
interface io_timer_if #(
  parameter int unsigned ADDR_LEN = 16,
  parameter int unsigned XLEN     = 32
) ();
  logic [ADDR_LEN-1:0] addr;
  logic                wr_req;
  logic [XLEN/8-1:0]   be;
  logic [XLEN-1:0]     wr_data;
  logic                wr_ready;
  logic                rd_req;
  logic [XLEN-1:0]     rd_data;
  logic                rd_ready;

  modport master (
    output addr, wr_req, be, wr_data, rd_req,
    input  wr_ready, rd_data, rd_ready
  );

  modport slave (
    input  addr, wr_req, be, wr_data, rd_req,
    output wr_ready, rd_data, rd_ready
  );
endinterface

// File: rtl/io_timer.sv
// Memory-mapped 64-bit timer: prescaled free-running mtime, 64-bit compare,
// sticky match flag with level irq, and a shadowed coherent 64-bit read.
module io_timer #(
  parameter int unsigned ADDR_LEN = 16,
  parameter int unsigned XLEN     = 32
) (
  input  logic      clk,
  input  logic      rstb_in,
  io_timer_if.slave bus,
  output logic      irq
);

  localparam logic [2:0] AddrCtrl    = 3'd0;
  localparam logic [2:0] AddrStatus  = 3'd1;
  localparam logic [2:0] AddrMtimeLo = 3'd2;
  localparam logic [2:0] AddrMtimeHi = 3'd3;
  localparam logic [2:0] AddrCmpLo   = 3'd4;
  localparam logic [2:0] AddrCmpHi   = 3'd5;

  logic            en_q, en_d;
  logic            irq_en_q, irq_en_d;
  logic            clr_q, clr_d;
  logic [7:0]      presc_q, presc_d;
  logic [7:0]      div_q, div_d;
  logic [63:0]     mtime_q, mtime_d;
  logic [63:0]     cmp_q, cmp_d;
  logic            flag_q, flag_d;
  logic [XLEN-1:0] shadow_q, shadow_d;
  logic            wr_ready_q, wr_ready_d;
  logic            rd_ready_q, rd_ready_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            irq_q, irq_d;

  logic [2:0]      reg_sel;
  logic            wr_fire;
  logic            rd_start;
  logic            tick;
  logic            match;
  logic [63:0]     mtime_inc;
  logic [XLEN-1:0] rd_mux;
  logic            unused_addr;

  // Upper address bits are decoded upstream; low bits are byte offsets.
  assign unused_addr = ^{bus.addr[ADDR_LEN-1:5], bus.addr[1:0]};
  assign reg_sel     = bus.addr[4:2];

  function automatic logic [XLEN-1:0] merge_be(input logic [XLEN-1:0]   old_val,
                                               input logic [XLEN-1:0]   new_val,
                                               input logic [XLEN/8-1:0] strb);
    logic [XLEN-1:0] res;
    res = old_val;
    for (int i = 0; i < XLEN / 8; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  always_comb begin
    wr_fire    = bus.wr_req & wr_ready_q;
    wr_ready_d = bus.wr_req & ~wr_ready_q;
    // A pending write always goes first; the read waits until wr_req drops.
    rd_start   = bus.rd_req & ~rd_ready_q & ~bus.wr_req;
    rd_ready_d = rd_start;

    tick  = en_q && (div_q == presc_q);
    match = (mtime_q == cmp_q);

    div_d = div_q;
    if (en_q) div_d = tick ? 8'd0 : div_q + 8'd1;

    mtime_inc = (match && clr_q) ? 64'd0 : mtime_q + 64'd1;
    mtime_d   = tick ? mtime_inc : mtime_q;

    en_d     = en_q;
    irq_en_d = irq_en_q;
    clr_d    = clr_q;
    presc_d  = presc_q;
    cmp_d    = cmp_q;
    flag_d   = flag_q;

    if (wr_fire) begin
      case (reg_sel)
        AddrCtrl: begin
          div_d = 8'd0;
          if (bus.be[0]) begin
            en_d     = bus.wr_data[0];
            irq_en_d = bus.wr_data[1];
            clr_d    = bus.wr_data[2];
          end
          if (bus.be[1]) presc_d = bus.wr_data[15:8];
        end
        AddrStatus: if (bus.be[0] && bus.wr_data[0]) flag_d = 1'b0;
        // Written bytes override the increment; unwritten bytes keep it.
        AddrMtimeLo: mtime_d[31:0]  = merge_be(mtime_d[31:0], bus.wr_data, bus.be);
        AddrMtimeHi: mtime_d[63:32] = merge_be(mtime_d[63:32], bus.wr_data, bus.be);
        AddrCmpLo:   cmp_d[31:0]    = merge_be(cmp_q[31:0], bus.wr_data, bus.be);
        AddrCmpHi:   cmp_d[63:32]   = merge_be(cmp_q[63:32], bus.wr_data, bus.be);
        default: ;
      endcase
    end

    if (match) flag_d = 1'b1;

    case (reg_sel)
      AddrCtrl:    rd_mux = {16'd0, presc_q, 5'd0, clr_q, irq_en_q, en_q};
      AddrStatus:  rd_mux = {31'd0, flag_q};
      AddrMtimeLo: rd_mux = mtime_q[31:0];
      AddrMtimeHi: rd_mux = shadow_q;
      AddrCmpLo:   rd_mux = cmp_q[31:0];
      AddrCmpHi:   rd_mux = cmp_q[63:32];
      default:     rd_mux = '0;
    endcase

    rd_data_d = rd_start ? rd_mux : '0;
    shadow_d  = (rd_start && reg_sel == AddrMtimeLo) ? mtime_q[63:32] : shadow_q;
    irq_d     = flag_q & irq_en_q;
  end

  always_ff @(posedge clk or negedge rstb_in) begin
    if (!rstb_in) begin
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      clr_q      <= 1'b0;
      presc_q    <= 8'd0;
      div_q      <= 8'd0;
      mtime_q    <= 64'd0;
      cmp_q      <= '1;
      flag_q     <= 1'b0;
      shadow_q   <= '0;
      wr_ready_q <= 1'b0;
      rd_ready_q <= 1'b0;
      rd_data_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      clr_q      <= clr_d;
      presc_q    <= presc_d;
      div_q      <= div_d;
      mtime_q    <= mtime_d;
      cmp_q      <= cmp_d;
      flag_q     <= flag_d;
      shadow_q   <= shadow_d;
      wr_ready_q <= wr_ready_d;
      rd_ready_q <= rd_ready_d;
      rd_data_q  <= rd_data_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.wr_ready = wr_ready_q;
  assign bus.rd_ready = rd_ready_q;
  assign bus.rd_data  = rd_data_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_io_timer.sv
// Self-checking bench for io_timer: register table, timing sequences,
// and randomized register/prescaler traffic against a simple model.
module tb_io_timer;

  logic clk = 1'b0;
  logic rstb_in;
  logic irq;

  io_timer_if #(.ADDR_LEN(16), .XLEN(32)) bus_if ();

  io_timer #(.ADDR_LEN(16), .XLEN(32)) dut (
    .clk     (clk),
    .rstb_in (rstb_in),
    .bus     (bus_if),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input logic [63:0] act,
                             input logic [63:0] lo, input logic [63:0] hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %h, expected within [%h, %h]", name, act, lo, hi);
    end
  endtask

  // Called on a negedge; returns on the negedge after the ack cycle.
  task automatic bus_write(input logic [15:0] a, input logic [3:0] b, input logic [31:0] d,
                           output int lat);
    lat = -1;
    bus_if.addr    = a;
    bus_if.be      = b;
    bus_if.wr_data = d;
    bus_if.wr_req  = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus_if.wr_ready) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wr_timeout: addr %h got no wr_ready, expected ack within 10 cycles", a);
    end
    @(negedge clk);
    bus_if.wr_req = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d, output int lat);
    lat = -1;
    d = '0;
    bus_if.addr   = a;
    bus_if.rd_req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus_if.rd_ready) begin
        lat = i;
        d   = bus_if.rd_data;
        break;
      end
    end
    if (lat < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rd_timeout: addr %h got no rd_ready, expected ack within 10 cycles", a);
    end
    @(negedge clk);
    bus_if.rd_req = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [3:0] b, input logic [31:0] d);
    int l;
    bus_write(a, b, d, l);
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    int l;
    bus_read(a, d, l);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, lo, hi, lo2, hi2, rdat;
    logic [31:0] ctrl_m;
    logic [63:0] cmp_m;
    logic [15:0] raddrs [5];
    int lat, k, wt, rt, presc, w;
    bit both;

    bus_if.addr    = '0;
    bus_if.wr_req  = 1'b0;
    bus_if.rd_req  = 1'b0;
    bus_if.be      = '0;
    bus_if.wr_data = '0;
    rstb_in        = 1'b0;

    // Reset holds everything quiet even with requests pending.
    @(negedge clk);
    bus_if.rd_req = 1'b1;
    bus_if.wr_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_quiet", {bus_if.wr_ready, bus_if.rd_ready, irq, bus_if.rd_data},
            {3'b000, 32'h0});
    end
    bus_if.rd_req = 1'b0;
    bus_if.wr_req = 1'b0;
    @(negedge clk);
    rstb_in = 1'b1;
    @(negedge clk);

    bus_read(16'h0000, d, lat);
    check("rst_ctrl_lat", lat, 1);
    check("rst_ctrl", d, 32'h0);
    bus_read(16'h0014, d, lat);
    check("rst_cmphi_lat", lat, 1);
    check("rst_cmphi", d, 32'hFFFF_FFFF);

    vecs[0]  = '{1'b0, 16'h0000, 4'h0, 32'h0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 16'h0004, 4'h0, 32'h0, 32'h0000_0000};
    vecs[2]  = '{1'b0, 16'h0008, 4'h0, 32'h0, 32'h0000_0000};
    vecs[3]  = '{1'b0, 16'h000C, 4'h0, 32'h0, 32'h0000_0000};
    vecs[4]  = '{1'b0, 16'h0010, 4'h0, 32'h0, 32'hFFFF_FFFF};
    vecs[5]  = '{1'b0, 16'h0014, 4'h0, 32'h0, 32'hFFFF_FFFF};
    vecs[6]  = '{1'b0, 16'h0018, 4'h0, 32'h0, 32'h0000_0000};
    vecs[7]  = '{1'b1, 16'h001C, 4'hF, 32'hDEAD_BEEF, 32'h0};
    vecs[8]  = '{1'b0, 16'h001C, 4'h0, 32'h0, 32'h0000_0000};
    vecs[9]  = '{1'b1, 16'h0000, 4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[10] = '{1'b0, 16'h0000, 4'h0, 32'h0, 32'h0000_FF07};
    vecs[11] = '{1'b1, 16'h0000, 4'hF, 32'h0, 32'h0};
    vecs[12] = '{1'b0, 16'h0000, 4'h0, 32'h0, 32'h0000_0000};
    vecs[13] = '{1'b1, 16'h0010, 4'b0010, 32'h0000_AB00, 32'h0};
    vecs[14] = '{1'b0, 16'h0010, 4'h0, 32'h0, 32'hFFFF_ABFF};
    vecs[15] = '{1'b0, 16'h0014, 4'h0, 32'h0, 32'hFFFF_FFFF};
    vecs[16] = '{1'b1, 16'h0004, 4'hF, 32'h0, 32'h0};
    vecs[17] = '{1'b0, 16'h0004, 4'h0, 32'h0, 32'h0000_0000};
    vecs[18] = '{1'b1, 16'h000C, 4'b1100, 32'hAABB_CCDD, 32'h0};
    vecs[19] = '{1'b0, 16'h0008, 4'h0, 32'h0, 32'h0000_0000};
    vecs[20] = '{1'b0, 16'h000C, 4'h0, 32'h0, 32'hAABB_0000};

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        wr(vecs[i].addr, vecs[i].be, vecs[i].data);
      end else begin
        rd(vecs[i].addr, d);
        check($sformatf("vec%0d_addr%h", i, vecs[i].addr), d, vecs[i].exp);
      end
    end

    // presc=3: one increment every 4 cycles.
    wr(16'h0008, 4'hF, 32'h0);
    wr(16'h000C, 4'hF, 32'h0);
    wr(16'h0000, 4'hF, 32'h0000_0301);
    repeat (40) @(negedge clk);
    rd(16'h0008, d);
    check_range("presc3_40cyc", d, 64'd9, 64'd11);

    // Coherent read across the 32-bit carry.
    wr(16'h0000, 4'hF, 32'h0);
    wr(16'h0008, 4'hF, 32'hFFFF_FFFF);
    wr(16'h000C, 4'hF, 32'h0);
    wr(16'h0000, 4'hF, 32'h0000_0301);
    rd(16'h0008, lo);
    repeat (4) @(negedge clk);
    rd(16'h000C, hi);
    check_range("shadow_pair1", {hi, lo}, 64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0001);
    rd(16'h0008, lo2);
    rd(16'h000C, hi2);
    check_range("shadow_pair2", {hi2, lo2}, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_000A);

    // Periodic match: 15..20 then wrap to 0, flag then irq.
    wr(16'h0000, 4'hF, 32'h0);
    wr(16'h0014, 4'hF, 32'h0);
    wr(16'h0010, 4'hF, 32'd20);
    wr(16'h000C, 4'hF, 32'h0);
    wr(16'h0008, 4'hF, 32'd15);
    wr(16'h0004, 4'hF, 32'h1);
    wr(16'h0000, 4'hF, 32'h0000_0007);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (irq) begin
        k = i;
        break;
      end
    end
    check("irq_latency", k, 7);
    rd(16'h0008, d);
    check_range("mtime_after_wrap", d, 64'd0, 64'd3);
    rd(16'h0004, d);
    check("status_set", d, 32'h1);
    wr(16'h0004, 4'hF, 32'h0);
    rd(16'h0004, d);
    check("status_w0_noop", d, 32'h1);
    wr(16'h0000, 4'hF, 32'h0000_0002);
    wr(16'h0008, 4'hF, 32'h0000_0100);
    check("irq_held", irq, 1'b1);
    wr(16'h0004, 4'hF, 32'h1);
    repeat (2) @(negedge clk);
    check("irq_after_w1c", irq, 1'b0);
    rd(16'h0004, d);
    check("status_cleared", d, 32'h0);
    // Frozen mtime equal to cmp: match re-sets the flag over the W1C.
    wr(16'h0008, 4'hF, 32'd20);
    wr(16'h0004, 4'hF, 32'h1);
    rd(16'h0004, d);
    check("status_set_wins", d, 32'h1);
    wr(16'h0008, 4'hF, 32'h0000_0100);
    wr(16'h0004, 4'hF, 32'h1);

    // Simultaneous write and read to the same register.
    bus_if.addr    = 16'h0010;
    bus_if.be      = 4'hF;
    bus_if.wr_data = 32'h1357_2468;
    bus_if.wr_req  = 1'b1;
    bus_if.rd_req  = 1'b1;
    wt = -1;
    rt = -1;
    both = 1'b0;
    rdat = '0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (wt >= 0 && i == wt + 1) bus_if.wr_req = 1'b0;
      if (rt >= 0 && i == rt + 1) bus_if.rd_req = 1'b0;
      if (bus_if.wr_ready && bus_if.rd_ready) both = 1'b1;
      if (bus_if.wr_ready && wt < 0) wt = i;
      if (bus_if.rd_ready && rt < 0) begin
        rt   = i;
        rdat = bus_if.rd_data;
      end
    end
    bus_if.wr_req = 1'b0;
    bus_if.rd_req = 1'b0;
    repeat (2) @(negedge clk);
    check("both_wr_ack", wt, 1);
    check("both_rd_ack", rt, 3);
    check("both_no_overlap", both, 1'b0);
    check("both_rd_data", rdat, 32'h1357_2468);

    // Random register traffic against a byte-enable model.
    raddrs = '{16'h0000, 16'h0010, 16'h0014, 16'h0018, 16'h001C};
    ctrl_m = 32'h0;
    cmp_m  = {$urandom, $urandom};
    wr(16'h0000, 4'hF, ctrl_m);
    wr(16'h0010, 4'hF, cmp_m[31:0]);
    wr(16'h0014, 4'hF, cmp_m[63:32]);
    for (int n = 0; n < 40; n++) begin
      logic [15:0] a;
      logic [3:0]  b;
      logic [31:0] v, e;
      a = raddrs[$urandom_range(0, 4)];
      if ($urandom_range(0, 1) == 1) begin
        b = 4'($urandom_range(0, 15));
        v = $urandom;
        wr(a, b, v);
        case (a)
          16'h0000: ctrl_m = merge(ctrl_m, v, b) & 32'h0000_FF07;
          16'h0010: cmp_m[31:0] = merge(cmp_m[31:0], v, b);
          16'h0014: cmp_m[63:32] = merge(cmp_m[63:32], v, b);
          default: ;
        endcase
      end else begin
        rd(a, v);
        case (a)
          16'h0000: e = ctrl_m;
          16'h0010: e = cmp_m[31:0];
          16'h0014: e = cmp_m[63:32];
          default:  e = 32'h0;
        endcase
        check($sformatf("rand_rd_%h", a), v, e);
      end
    end

    // Random prescaler: count = elapsed cycles / (presc + 1).
    for (int n = 0; n < 3; n++) begin
      presc = $urandom_range(0, 7);
      w     = $urandom_range(60, 200);
      wr(16'h0000, 4'hF, 32'h0);
      wr(16'h0008, 4'hF, 32'h0);
      wr(16'h000C, 4'hF, 32'h0);
      wr(16'h0000, 4'hF, {16'h0, 8'(presc), 8'h01});
      repeat (w) @(negedge clk);
      rd(16'h0008, d);
      check_range($sformatf("rand_presc%0d_w%0d", presc, w), d,
                  64'(w / (presc + 1) - 1), 64'(w / (presc + 1) + 1));
    end

    // Reset in the middle of a read acknowledge.
    bus_if.addr   = 16'h0010;
    bus_if.rd_req = 1'b1;
    @(negedge clk);
    check("midrst_pre_ready", bus_if.rd_ready, 1'b1);
    rstb_in = 1'b0;
    #1;
    check("midrst_outputs", {bus_if.rd_ready, bus_if.wr_ready, bus_if.rd_data}, 34'h0);
    repeat (2) @(negedge clk);
    check("midrst_held", bus_if.rd_ready, 1'b0);
    bus_if.rd_req = 1'b0;
    @(negedge clk);
    rstb_in = 1'b1;
    @(negedge clk);
    rd(16'h0000, d);
    check("post_rst_ctrl", d, 32'h0);
    rd(16'h0010, d);
    check("post_rst_cmplo", d, 32'hFFFF_FFFF);
    rd(16'h0008, d);
    check("post_rst_mtime", d, 32'h0);
    rd(16'h0004, d);
    check("post_rst_status", d, 32'h0);
    check("post_rst_irq", irq, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
